led_digit_scanner: RTL and testbench
====================================

LED_DIGIT_SCANNER -- requirements
Module: led_digit_scanner

Interface
REQ-001 SHALL have parameter DWELL, default 1000, giving the cycles each column is lit (legal range 1..65535).
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port load  input  1  one-cycle strobe capturing digits.
REQ-005 SHALL have port digits  input  16  four BCD nibbles; [3:0] is leftmost digit 0, [15:12] is digit 3.
REQ-006 SHALL have port col_sel  output  16  one-hot active-low column enable; bit c drives matrix column c.
REQ-007 SHALL have port row_data  output  8  active-low pixel data for the enabled column.
REQ-008 SHALL have port pending  output  1  high while a captured value awaits the next frame boundary.
REQ-009 SHALL have port frame_done  output  1  one-cycle pulse after column 15's gap cycle.

Function
REQ-010 SHALL hold a pending register and an active register, each 16 bits.
REQ-011 On load, SHALL copy digits into pending and set pending; a later load before application SHALL overwrite it (last wins).
REQ-012 SHALL run the FSM BLANK -> FETCH -> SHOW -> GAP -> FETCH ...; BLANK is left only when pending is set.
REQ-013 BLANK: col_sel = 16'hFFFF, row_data = 8'hFF; with pending set, SHALL copy pending to active, clear pending, set column = 0, and go to FETCH next cycle.
REQ-014 FETCH (1 cycle): col_sel all ones; SHALL register the font column of digit column>>2 at font index column[1:0] into row_data.
REQ-015 SHALL select the font column combinationally; the registered row_data is the only font latency.
REQ-016 SHOW (DWELL cycles): col_sel SHALL have exactly bit [column] low; row_data stable.
REQ-017 GAP (1 cycle, anti-ghosting): col_sel = 16'hFFFF and row_data = 8'hFF.
REQ-018 After GAP, if column < 15, SHALL increment column and go to FETCH.
REQ-019 After GAP, if column = 15, SHALL wrap column to 0 and pulse frame_done in the following cycle.
REQ-020 At wrap, if pending is set, SHALL copy pending to active and clear pending in the same cycle.
REQ-021 A load coinciding with the wrap cycle SHALL NOT be applied at that wrap; it is captured and applied at the next wrap.
REQ-022 The active register SHALL change only at BLANK exit or at a wrap, never mid-frame.
REQ-023 Frame length SHALL be exactly 16*(DWELL+2) cycles.
REQ-024 Font glyphs for 0-9 SHALL use the team's standard 4x8 active-low glyph table.
REQ-025 A nibble of 10-15 SHALL display blank (8'hFF) in all four of its columns.
REQ-026 The dwell counter SHALL be 16 bits and SHALL count DWELL-1 down to 0.

Reset
REQ-027 On rst_n low, asynchronously: state BLANK, column 0, dwell counter 0, active 16'h0000, pending register 16'h0000, pending 0, col_sel 16'hFFFF, row_data 8'hFF, frame_done 0.
REQ-028 Reset mid-frame SHALL discard the frame and any pending value; after release the display stays blank until a load.

Structure
REQ-029 A shared package/include SHALL hold the state encodings (2-bit), NUM_COLS=16, COLS_PER_DIGIT=4, and the blank column constant 8'hFF.
REQ-030 The glyph table SHALL be a separate combinational sub-module led_digit_font, with inputs bcd[3:0] and col[1:0] and output col_bits[7:0] (blank for nibbles >9).
REQ-031 Everything else SHALL be in led_digit_scanner; no other sub-modules.

Verification (DWELL=2, frame 64 cycles)
REQ-032 Reset release with no load -> col_sel 16'hFFFF, row_data 8'hFF, and frame_done stays 0 for 200 cycles.
REQ-033 Load digits=16'h4321 -> BLANK exit next cycle; column 0 shows digit 1's column 0 (8'hFF) for 2 cycles with col_sel 16'hFFFE; first frame_done 64 cycles after FETCH starts.
REQ-034 Load 16'h0008 then 16'h0009 mid-frame -> pending stays 1; next frame shows 9 only (last wins); columns 0-3 not 8.
REQ-035 Load asserted on the wrap cycle -> value is not shown in the next frame, appears in the one after; pending is 1 for >64 cycles.
REQ-036 Digits 16'hF0A5 -> columns 4-7 (A) and 12-15 (F) all 8'hFF; digit 0 and digit 2 glyphs correct.
REQ-037 rst_n pulsed low mid-SHOW -> col_sel 16'hFFFF in the same cycle (asynchronous); display blank after release until the next load.

Source files
------------

// File: rtl/led_digit_scanner_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | led_digit_scanner_pkg: shared state encodings and matrix constants  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package led_digit_scanner_pkg;

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHOW  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  localparam int          NUM_COLS       = 16;
  localparam int          COLS_PER_DIGIT = 4;
  localparam logic [7:0]  BLANK_COL      = 8'hFF;
  localparam logic [15:0] COLS_OFF       = 16'hFFFF;

endpackage
`default_nettype wire

// File: rtl/led_digit_font.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | led_digit_font: 4x8 active-low glyph columns for BCD digits 0-9     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module led_digit_font
  import led_digit_scanner_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic [1:0] col,
  output logic [7:0] col_bits
);

  // Glyph words are packed {col3, col2, col1, col0}; bit 0 is the top row.
  logic [31:0] w_glyph;

  always_comb begin
    w_glyph = {4{BLANK_COL}};
    case (bcd)
      4'd0: w_glyph = 32'hC1BEBEC1;
      4'd1: w_glyph = 32'hBF80BDFF;
      4'd2: w_glyph = 32'hB9B6AE9D;
      4'd3: w_glyph = 32'hC9B6B6DD;
      4'd4: w_glyph = 32'hEF80EBE7;
      4'd5: w_glyph = 32'hC6BABAD8;
      4'd6: w_glyph = 32'hCDB6B6C1;
      4'd7: w_glyph = 32'hF8F68EFE;
      4'd8: w_glyph = 32'hC9B6B6C9;
      4'd9: w_glyph = 32'hC1B6B6D9;
      default: w_glyph = {4{BLANK_COL}};
    endcase
    col_bits = w_glyph[{col, 3'b000} +: 8];
  end

endmodule
`default_nettype wire

// File: rtl/led_digit_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | led_digit_scanner: column-multiplexed 4-digit LED matrix driver     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module led_digit_scanner
  import led_digit_scanner_pkg::*;
#(
  parameter int DWELL = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] digits,
  output logic [15:0] col_sel,
  output logic [7:0]  row_data,
  output logic        pending,
  output logic        frame_done
);

  localparam logic [15:0] DWELL_LOAD = 16'(DWELL - 1);
  localparam logic [3:0]  LAST_COL   = 4'(NUM_COLS - 1);

  state_t      r_state;
  logic [3:0]  r_column;
  logic [15:0] r_dwell;
  logic [15:0] r_active;
  logic [15:0] r_pend_val;

  logic [3:0]  w_bcd;
  logic [7:0]  w_font_col;
  logic [15:0] w_col_on;

  always_comb begin
    w_bcd = r_active[3:0];
    case (r_column[3:2])
      2'd0: w_bcd = r_active[3:0];
      2'd1: w_bcd = r_active[7:4];
      2'd2: w_bcd = r_active[11:8];
      2'd3: w_bcd = r_active[15:12];
      default: w_bcd = r_active[3:0];
    endcase
    w_col_on = ~(16'h0001 << r_column);
  end

  led_digit_font u_font (
    .bcd      (w_bcd),
    .col      (r_column[1:0]),
    .col_bits (w_font_col)
  );

  // Outputs are registered so that they reflect the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_BLANK;
      r_column   <= 4'd0;
      r_dwell    <= 16'd0;
      r_active   <= 16'h0000;
      r_pend_val <= 16'h0000;
      pending    <= 1'b0;
      col_sel    <= COLS_OFF;
      row_data   <= BLANK_COL;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (r_state)
        ST_BLANK: begin
          col_sel  <= COLS_OFF;
          row_data <= BLANK_COL;
          if (pending) begin
            r_active <= r_pend_val;
            pending  <= 1'b0;
            r_column <= 4'd0;
            r_state  <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          row_data <= w_font_col;
          col_sel  <= w_col_on;
          r_dwell  <= DWELL_LOAD;
          r_state  <= ST_SHOW;
        end
        ST_SHOW: begin
          if (r_dwell == 16'd0) begin
            col_sel  <= COLS_OFF;
            row_data <= BLANK_COL;
            r_state  <= ST_GAP;
          end else begin
            r_dwell <= r_dwell - 16'd1;
          end
        end
        ST_GAP: begin
          r_state <= ST_FETCH;
          if (r_column == LAST_COL) begin
            r_column   <= 4'd0;
            frame_done <= 1'b1;
            if (pending) begin
              r_active <= r_pend_val;
              pending  <= 1'b0;
            end
          end else begin
            r_column <= r_column + 4'd1;
          end
        end
        default: r_state <= ST_BLANK;
      endcase
      // A load on the same edge as an apply is kept for the next boundary.
      if (load) begin
        r_pend_val <= digits;
        pending    <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_digit_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_led_digit_scanner: directed self-checking bench, DWELL = 2       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_led_digit_scanner;

  localparam int DWELL = 2;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b1;
  logic        load   = 1'b0;
  logic [15:0] digits = 16'h0000;
  logic [15:0] col_sel;
  logic [7:0]  row_data;
  logic        pending;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  logic [15:0] cur_val  = 16'h0000;
  logic [15:0] pend_val = 16'h0000;
  bit          exp_pend = 1'b0;

  led_digit_scanner #(.DWELL(DWELL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .digits     (digits),
    .col_sel    (col_sel),
    .row_data   (row_data),
    .pending    (pending),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Reference glyph columns, written column 0 first: {c0, c1, c2, c3}.
  function automatic logic [7:0] glyph(input logic [15:0] d, input int c);
    logic [3:0]  nib;
    logic [31:0] w;
    nib = d[(c / 4) * 4 +: 4];
    case (nib)
      4'd0: w = 32'hC1BEBEC1;
      4'd1: w = 32'hFFBD80BF;
      4'd2: w = 32'h9DAEB6B9;
      4'd3: w = 32'hDDB6B6C9;
      4'd4: w = 32'hE7EB80EF;
      4'd5: w = 32'hD8BABAC6;
      4'd6: w = 32'hC1B6B6CD;
      4'd7: w = 32'hFE8EF6F8;
      4'd8: w = 32'hC9B6B6C9;
      4'd9: w = 32'hD9B6B6C1;
      default: w = 32'hFFFFFFFF;
    endcase
    return w[31 - 8 * (c % 4) -: 8];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input logic [15:0] v);
    load   = 1'b1;
    digits = v;
    step();
    load     = 1'b0;
    exp_pend = 1'b1;
    pend_val = v;
  endtask

  // Walks one full frame starting in FETCH of column 0; optional loads at
  // the FETCH cycle of two columns and on the wrap (column 15 GAP) cycle.
  task automatic check_frame(input bit fd0,
                             input int lc1, input logic [15:0] v1,
                             input int lc2, input logic [15:0] v2,
                             input bit lw,  input logic [15:0] vw);
    logic [15:0] exp_col;
    for (int c = 0; c < 16; c++) begin
      checks++;
      if (col_sel !== 16'hFFFF || row_data !== 8'hFF) begin
        errors++;
        $display("FAIL fetch_col%0d: col_sel=%h row_data=%h expected FFFF/FF", c, col_sel, row_data);
      end
      checks++;
      if (frame_done !== ((c == 0) && fd0)) begin
        errors++;
        $display("FAIL fetch_frame_done col%0d: got %b expected %b", c, frame_done, (c == 0) && fd0);
      end
      checks++;
      if (pending !== exp_pend) begin
        errors++;
        $display("FAIL fetch_pending col%0d: got %b expected %b", c, pending, exp_pend);
      end
      if (c == lc1) begin
        load = 1'b1; digits = v1;
      end else if (c == lc2) begin
        load = 1'b1; digits = v2;
      end
      step();
      if (load) begin
        exp_pend = 1'b1;
        pend_val = digits;
      end
      load = 1'b0;
      exp_col = ~(16'h0001 << c);
      for (int k = 0; k < DWELL; k++) begin
        checks++;
        if (col_sel !== exp_col || row_data !== glyph(cur_val, c)) begin
          errors++;
          $display("FAIL show_col%0d: col_sel=%h row_data=%h expected %h/%h", c, col_sel, row_data,
                   exp_col, glyph(cur_val, c));
        end
        checks++;
        if (frame_done !== 1'b0 || pending !== exp_pend) begin
          errors++;
          $display("FAIL show_flags col%0d: frame_done=%b pending=%b expected 0/%b", c, frame_done,
                   pending, exp_pend);
        end
        step();
      end
      checks++;
      if (col_sel !== 16'hFFFF || row_data !== 8'hFF || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL gap_col%0d: col_sel=%h row_data=%h frame_done=%b expected FFFF/FF/0", c,
                 col_sel, row_data, frame_done);
      end
      if (c == 15 && lw) begin
        load = 1'b1; digits = vw;
      end
      step();
      load = 1'b0;
      if (c == 15) begin
        if (exp_pend) begin
          cur_val  = pend_val;
          exp_pend = 1'b0;
        end
        if (lw) begin
          exp_pend = 1'b1;
          pend_val = vw;
        end
      end
    end
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL frame_done_pulse: got %b expected 1", frame_done);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (col_sel !== 16'hFFFF || row_data !== 8'hFF || frame_done !== 1'b0 || pending !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: col_sel=%h row_data=%h frame_done=%b pending=%b expected FFFF/FF/0/0",
               col_sel, row_data, frame_done, pending);
    end
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      checks++;
      if (col_sel !== 16'hFFFF || row_data !== 8'hFF || frame_done !== 1'b0 || pending !== 1'b0) begin
        errors++;
        $display("FAIL idle_blank cycle %0d: col_sel=%h row_data=%h frame_done=%b pending=%b", i,
                 col_sel, row_data, frame_done, pending);
      end
    end
  endtask

  task automatic test_first_frame();
    pulse_load(16'h4321);
    checks++;
    if (pending !== 1'b1 || col_sel !== 16'hFFFF) begin
      errors++;
      $display("FAIL load_capture: pending=%b col_sel=%h expected 1/FFFF", pending, col_sel);
    end
    step();
    cur_val  = pend_val;
    exp_pend = 1'b0;
    check_frame(1'b0, -1, 16'h0, -1, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic test_last_wins();
    check_frame(1'b1, 2, 16'h0008, 9, 16'h0009, 1'b0, 16'h0);
    checks++;
    if (cur_val !== 16'h0009) begin
      errors++;
      $display("FAIL last_wins_model: got %h expected 0009", cur_val);
    end
    check_frame(1'b1, -1, 16'h0, -1, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic test_load_on_wrap();
    check_frame(1'b1, -1, 16'h0, -1, 16'h0, 1'b1, 16'h5678);
    check_frame(1'b1, -1, 16'h0, -1, 16'h0, 1'b0, 16'h0);
    check_frame(1'b1, -1, 16'h0, -1, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic test_hex_blank();
    check_frame(1'b1, 3, 16'hF0A5, -1, 16'h0, 1'b0, 16'h0);
    check_frame(1'b1, -1, 16'h0, -1, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic test_async_reset();
    step();
    checks++;
    if (col_sel !== 16'hFFFE || row_data !== 8'hD8) begin
      errors++;
      $display("FAIL pre_reset_show: col_sel=%h row_data=%h expected FFFE/D8", col_sel, row_data);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (col_sel !== 16'hFFFF || row_data !== 8'hFF) begin
      errors++;
      $display("FAIL async_reset: col_sel=%h row_data=%h expected FFFF/FF", col_sel, row_data);
    end
    step();
    step();
    rst_n    = 1'b1;
    exp_pend = 1'b0;
    cur_val  = 16'h0000;
    for (int i = 0; i < 100; i++) begin
      step();
      checks++;
      if (col_sel !== 16'hFFFF || row_data !== 8'hFF || frame_done !== 1'b0 || pending !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_blank cycle %0d: col_sel=%h row_data=%h frame_done=%b pending=%b",
                 i, col_sel, row_data, frame_done, pending);
      end
    end
  endtask

  task automatic test_back_to_back();
    pulse_load(16'h1234);
    load   = 1'b1;
    digits = 16'h9876;
    step();
    load     = 1'b0;
    cur_val  = pend_val;
    exp_pend = 1'b1;
    pend_val = 16'h9876;
    check_frame(1'b0, -1, 16'h0, -1, 16'h0, 1'b0, 16'h0);
    check_frame(1'b1, -1, 16'h0, -1, 16'h0, 1'b0, 16'h0);
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_last_wins();
    test_load_on_wrap();
    test_hex_blank();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
